// File: rtl/seq_mul_08.sv
// Multi-cycle unsigned 8x8 shift-and-add multiplier with valid/ready handshakes,
// driving an 8-bit carry-lookahead adder to build the partial product.

module cla_08 (
  input  logic [7:0] src1,
  input  logic [7:0] src2,
  input  logic       carry_in,
  input  logic       sub_flag,
  output logic [7:0] sum,
  output logic       carry_out
);
  localparam int unsigned W = 8;

  logic [W-1:0] b;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         acc;
  logic         pp;

  assign b = src2 ^ {W{sub_flag}};
  assign g = src1 & b;
  assign p = src1 ^ b;

  // Each carry is a flat sum of generate terms gated by the propagates below it.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = carry_in | sub_flag;
    for (int i = 0; i < W; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & c[0]);
    end
  end

  assign sum       = p ^ c[W-1:0];
  assign carry_out = c[W];
endmodule

module seq_mul_08 #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  m, m_n;
  logic [W-1:0]  a, a_n;
  logic [W-1:0]  q, q_n;
  logic          c, c_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic [W-1:0]  post_a;
  logic          post_c;

  cla_08 u_cla (
    .src1      (a),
    .src2      (m),
    .carry_in  (1'b0),
    .sub_flag  (1'b0),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      a     <= '0;
      q     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      m     <= m_n;
      a     <= a_n;
      q     <= q_n;
      c     <= c_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    m_n     = m;
    a_n     = a;
    q_n     = q;
    c_n     = c;
    cnt_n   = cnt;
    post_a  = a;
    post_c  = c;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          m_n     = multiplicand;
          q_n     = multiplier;
          a_n     = '0;
          c_n     = 1'b0;
          cnt_n   = '0;
          state_n = RUN;
          if (SKIP_ZERO && ((multiplicand == '0) || (multiplier == '0))) begin
            q_n     = '0;
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (q[0]) begin
          post_a = add_sum;
          post_c = add_cout;
        end
        // Add then shift {C,A,Q} right by one; a zero enters at the top.
        c_n   = 1'b0;
        a_n   = {post_c, post_a[W-1:1]};
        q_n   = {post_a[0], q[W-1:1]};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(W - 1)) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign product   = {a, q};
endmodule

// File: tb/tb_seq_mul_08.sv
// Directed bench for seq_mul_08: one instance with SKIP_ZERO=0 and one with SKIP_ZERO=1.

module tb_seq_mul_08;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mcand, mplier;
  logic        out_ready;

  logic        in_valid, in_ready, out_valid, busy;
  logic [15:0] product;
  logic        in_valid_s, in_ready_s, out_valid_s, busy_s;
  logic [15:0] product_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_mul_08 #(.SKIP_ZERO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(mcand), .multiplier(mplier), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_mul_08 #(.SKIP_ZERO(1'b1)) dut_sz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .multiplicand(mcand), .multiplier(mplier), .out_valid(out_valid_s),
    .out_ready(out_ready), .product(product_s), .busy(busy_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: lat = edges after the accept edge until out_valid is seen.
  task automatic accept_op(input bit sel, input logic [7:0] m, input logic [7:0] q,
                           output int lat, output int busy_cnt);
    int guard = 0;
    mcand  = m;
    mplier = q;
    while (!(sel ? in_ready_s : in_ready) && guard < 100) begin
      tick();
      guard++;
    end
    if (sel) in_valid_s = 1'b1; else in_valid = 1'b1;
    tick();
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
    mcand      = ~m;
    mplier     = ~q;
    lat        = 0;
    busy_cnt   = 0;
    while (!(sel ? out_valid_s : out_valid) && lat < 40) begin
      if (sel ? busy_s : busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_valid_s = 1'b1; out_ready = 1'b0;
    mcand = 8'h13; mplier = 8'h07;
    repeat (3) tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL reset_ctl got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    n_cmp++; if (product !== 16'h0000)
      begin n_bad++; $display("FAIL reset_prod got %h want 0000", product); end
    n_cmp++; if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0 || busy_s !== 1'b0 || product_s !== 16'h0000)
      begin n_bad++; $display("FAIL reset_sz got rdy=%b vld=%b busy=%b p=%h want 1 0 0 0000", in_ready_s, out_valid_s, busy_s, product_s); end
    in_valid = 1'b0; in_valid_s = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0)
      begin n_bad++; $display("FAIL post_reset got rdy=%b busy=%b want 1 0", in_ready, busy); end
  endtask

  task automatic test_basic();
    int lat, bc;
    out_ready = 1'b1;
    accept_op(1'b0, 8'd13, 8'd11, lat, bc);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_lat got %0d want 8", lat); end
    n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL basic_busy got %0d want 8", bc); end
    n_cmp++; if (product !== 16'h008F) begin n_bad++; $display("FAIL basic_prod got %h want 008f", product); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0)
      begin n_bad++; $display("FAIL basic_done_ctl got busy=%b rdy=%b want 0 0", busy, in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL basic_handshake got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_extremes();
    int lat, bc;
    out_ready = 1'b1;
    accept_op(1'b0, 8'hFF, 8'hFF, lat, bc);
    n_cmp++; if (lat !== 8 || product !== 16'hFE01)
      begin n_bad++; $display("FAIL ff_x_ff got lat=%0d p=%h want 8 fe01", lat, product); end
    tick();
    accept_op(1'b0, 8'h80, 8'h02, lat, bc);
    n_cmp++; if (lat !== 8 || product !== 16'h0100)
      begin n_bad++; $display("FAIL 80_x_02 got lat=%0d p=%h want 8 0100", lat, product); end
    tick();
    accept_op(1'b0, 8'h01, 8'h80, lat, bc);
    n_cmp++; if (lat !== 8 || product !== 16'h0080)
      begin n_bad++; $display("FAIL 01_x_80 got lat=%0d p=%h want 8 0080", lat, product); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, bc;
    out_ready = 1'b0;
    accept_op(1'b0, 8'h12, 8'h34, lat, bc);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL bp_lat got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (product !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin n_bad++; $display("FAIL bp_hold[%0d] got p=%h vld=%b rdy=%b want 03a8 1 0", i, product, out_valid, in_ready); end
      tick();
    end
    n_cmp++; if (product !== 16'h03A8 || out_valid !== 1'b1)
      begin n_bad++; $display("FAIL bp_last got p=%h vld=%b want 03a8 1", product, out_valid); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_zero();
    int lat, bc;
    out_ready = 1'b1;
    accept_op(1'b0, 8'h00, 8'h5A, lat, bc);
    n_cmp++; if (lat !== 8 || product !== 16'h0000)
      begin n_bad++; $display("FAIL zero_noskip got lat=%0d p=%h want 8 0000", lat, product); end
    tick();
    // The skipping instance completes on the accept edge itself.
    accept_op(1'b1, 8'h00, 8'h5A, lat, bc);
    n_cmp++; if (lat !== 0 || product_s !== 16'h0000 || bc !== 0)
      begin n_bad++; $display("FAIL zero_skip_m got lat=%0d p=%h busy=%0d want 0 0000 0", lat, product_s, bc); end
    tick();
    n_cmp++; if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0)
      begin n_bad++; $display("FAIL zero_skip_hs got rdy=%b vld=%b want 1 0", in_ready_s, out_valid_s); end
    accept_op(1'b1, 8'h5A, 8'h00, lat, bc);
    n_cmp++; if (lat !== 0 || product_s !== 16'h0000)
      begin n_bad++; $display("FAIL zero_skip_q got lat=%0d p=%h want 0 0000", lat, product_s); end
    tick();
    accept_op(1'b1, 8'h03, 8'h05, lat, bc);
    n_cmp++; if (lat !== 8 || product_s !== 16'h000F)
      begin n_bad++; $display("FAIL skip_nonzero got lat=%0d p=%h want 8 000f", lat, product_s); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    out_ready = 1'b1;
    mcand = 8'hAB; mplier = 8'hCD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000)
      begin n_bad++; $display("FAIL mid_reset got busy=%b rdy=%b vld=%b p=%h want 0 1 0 0000", busy, in_ready, out_valid, product); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) rst_n = 1'b1;
      n_cmp++; if (out_valid !== 1'b0)
        begin n_bad++; $display("FAIL mid_no_valid[%0d] got %b want 0", i, out_valid); end
    end
    accept_op(1'b0, 8'h03, 8'h07, lat, bc);
    n_cmp++; if (lat !== 8 || product !== 16'h0015)
      begin n_bad++; $display("FAIL after_reset got lat=%0d p=%h want 8 0015", lat, product); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc, stall;
    logic [7:0]  m, q;
    logic [15:0] exp_p;
    for (int i = 0; i < 300; i++) begin
      m     = 8'($urandom);
      q     = 8'($urandom);
      exp_p = 16'(m) * 16'(q);
      stall = int'($urandom_range(0, 3));
      out_ready = (stall == 0);
      accept_op(1'b0, m, q, lat, bc);
      repeat (stall) tick();
      n_cmp++; if (lat !== 8 || product !== exp_p || out_valid !== 1'b1)
        begin n_bad++; $display("FAIL b2b[%0d] %h*%h got lat=%0d p=%h vld=%b want 8 %h 1", i, m, q, lat, product, out_valid, exp_p); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin n_bad++; $display("FAIL b2b_dup[%0d] got vld=%b rdy=%b want 0 1", i, out_valid, in_ready); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b0;
    mcand = '0; mplier = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
